kbd_seg_ctrl: RTL and testbench
===============================

KBD_SEG_CTRL -- requirements
Module: kbd_seg_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, scancode FIFO entries; power of two, 2..64.
REQ-002 Parameter TIMEOUT_CYC, default 50000, idle clock cycles after which a partial PS/2 frame is abandoned.
REQ-003 Parameter SEG_ACTIVE_LOW, default 1, 1 = segment lit by 0.
REQ-004 clock  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ps2_clk, ps2_data  in  1 each  raw asynchronous PS/2 lines.
REQ-007 io_seg1..io_seg6  out  7 each  digits: last code lo/hi, ASCII lo/hi, press count lo/hi.
REQ-008 key_held  out  1  a make code is held, no matching break yet.
REQ-009 parity_err  out  1  one-cycle pulse per rejected frame.
REQ-010 overflow  out  1  sticky; byte dropped on full FIFO.

Function
REQ-011 SHALL pass ps2_clk/ps2_data through 3-flop synchronisers and sample data on each detected ps2_clk falling edge.
REQ-012 SHALL receive 11-bit frames: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-013 Start bit 1: SHALL ignore the edge and stay idle.
REQ-014 Bad stop bit: SHALL discard the byte and pulse parity_err.
REQ-015 TIMEOUT_CYC cycles without a falling edge mid-frame: SHALL reset bit counter, no error pulse.
REQ-016 Good frame: SHALL write the byte to the FIFO in the cycle after the stop-bit edge.
REQ-017 FIFO full on write: SHALL drop the byte and set overflow until reset.
REQ-018 Decoder SHALL pop at most one byte per cycle when FIFO non-empty; simultaneous push and pop on full FIFO is accepted, no overflow.
REQ-019 Decoder FSM states: IDLE, EXT, BRK, EXT_BRK.
REQ-020 IDLE: E0 -> EXT; F0 -> BRK; other byte = make code.
REQ-021 EXT: F0 -> EXT_BRK; other byte = extended make code -> IDLE.
REQ-022 BRK / EXT_BRK: byte = break code; if equal to held code (with ext flag) clear key_held; -> IDLE.
REQ-023 Make code differing from held code, or with key_held 0: SHALL latch code and ext flag, set key_held, increment 8-bit press count modulo 256.
REQ-024 Make code equal to held code (typematic repeat): SHALL NOT increment count.
REQ-025 ASCII: set-2 codes for A-Z -> 0x41..0x5A, 0-9 -> 0x30..0x39, Space -> 0x20; extended or unmapped -> 0x00.
REQ-026 Digits SHALL show hex 0-F; io_seg1..io_seg4 blank (all segments off) while key_held is 0; io_seg5/6 always show count.
REQ-027 Outputs registered; first make byte to display latency = 2 cycles after FIFO write when FIFO empty.

Reset
REQ-028 On reset: FSM IDLE, FIFO empty, receiver idle, count 0, last code 0, key_held 0, overflow 0, parity_err 0.
REQ-029 Reset outputs: io_seg1..4 blank, io_seg5/6 show "0".
REQ-030 Reset mid-frame or with FIFO occupied SHALL discard all partial and queued data.

Configuration
REQ-031 Macro KBD_PARITY_CHK_EN defined: parity mismatch discards byte and pulses parity_err.
REQ-032 Macro undefined: parity bit ignored; parity_err pulses only on bad stop bit.

Structure
REQ-033 Package kbd_pkg SHALL hold decoder state enum, constants E0/F0, frame length 11, blank segment pattern, hex-to-segment table.
REQ-034 Sub-module ps2_rx SHALL contain synchroniser, edge detect, frame shift register, timeout and parity check; FIFO, decoder, display stay in kbd_seg_ctrl.

Verification
REQ-035 Frame 0x1C ('A') -> key_held 1, io_seg1/2 "C"/"1", io_seg3/4 "1"/"4", count 1.
REQ-036 Sequence 1C,1C,1C,F0,1C -> count 1, key_held 0, io_seg1..4 blank.
REQ-037 E0 75, E0 F0 75 -> count 1, ASCII digits "0"/"0", key_held 0 at end.
REQ-038 Frame with wrong parity, macro defined -> parity_err one cycle, FIFO unchanged; macro undefined -> byte accepted.
REQ-039 FIFO_DEPTH+1 frames with decoder stalled by bench force -> overflow 1, first FIFO_DEPTH bytes decoded in order.
REQ-040 256 distinct alternating make codes -> count wraps to 0x00, io_seg5/6 "0"/"0"; 5 bits then TIMEOUT_CYC idle, then frame 0x1B -> 0x1B decoded correctly.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard to seven-segment controller:
// decoder states, protocol bytes, segment encodings and the set-2 ASCII map.
package kbd_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} dec_state_t;

    typedef struct packed {
        logic make;
        logic brk;
        logic ext;
    } dec_act_t;

    localparam logic [7:0] CODE_E0    = 8'hE0;
    localparam logic [7:0] CODE_F0    = 8'hF0;
    localparam int         FRAME_BITS = 11;

    // Segment patterns are gfedcba, active-high; polarity is applied at the pins.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic ext);
        logic [7:0] a;
        a = 8'h00;
        if (!ext) begin
            case (code)
                8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
                8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
                8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
                8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
                8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
                8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
                8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
                8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
                8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
                8'h3E: a = 8'h38; 8'h46: a = 8'h39;
                8'h29: a = 8'h20;
                default: a = 8'h00;
            endcase
        end
        return a;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronisers, falling-edge detect, 11-bit frame capture
// and mid-frame timeout. Define KBD_PARITY_CHK_EN to also reject odd-parity errors.
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       frame_err
);

`ifdef KBD_PARITY_CHK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]    clk_sync, dat_sync;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] idle_cnt;
    logic          fall, din, frame_ok;

    assign fall     = clk_sync[2] & ~clk_sync[1];
    assign din      = dat_sync[1];
    // din here is the stop bit; parity covers data plus parity bit (odd).
    assign frame_ok = din & (~PAR_EN | (^{shreg, par_bit}));

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync  <= '1;
            dat_sync  <= '1;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            idle_cnt  <= '0;
            byte_vld  <= 1'b0;
            byte_data <= '0;
            frame_err <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            dat_sync  <= {dat_sync[1:0], ps2_data};
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'd0) begin
                    if (!din) bit_cnt <= 4'd1;
                end else if (bit_cnt <= 4'd8) begin
                    shreg   <= {din, shreg[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd9) begin
                    par_bit <= din;
                    bit_cnt <= 4'd10;
                end else begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        byte_vld  <= 1'b1;
                        byte_data <= shreg;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end else if (bit_cnt != 4'd0) begin
                // A stalled partial frame is dropped silently.
                if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

    logic unused_len;
    assign unused_len = (FRAME_BITS == 11);

endmodule

// File: rtl/kbd_seg_ctrl.sv
// PS/2 keyboard to six-digit seven-segment display: scancode FIFO, set-2 decoder
// and registered display. Parity checking in ps2_rx follows KBD_PARITY_CHK_EN.
module kbd_seg_ctrl
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYC    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [6:0] io_seg1,
    output logic [6:0] io_seg2,
    output logic [6:0] io_seg3,
    output logic [6:0] io_seg4,
    output logic [6:0] io_seg5,
    output logic [6:0] io_seg6,
    output logic       key_held,
    output logic       parity_err,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    function automatic logic [6:0] seg_out(input logic [6:0] s);
        return SEG_ACTIVE_LOW ? ~s : s;
    endfunction

    logic       rx_vld, rx_err;
    logic [7:0] rx_byte;

    ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clock     (clock),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_vld  (rx_vld),
        .byte_data (rx_byte),
        .frame_err (rx_err)
    );

    assign parity_err = rx_err;

    // Scancode FIFO; pointers carry a wrap bit to tell full from empty.
    logic [FIFO_DEPTH-1:0][7:0] mem;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, fifo_push, fifo_pop, dec_stall;
    logic [7:0]  pop_byte;

    assign dec_stall = 1'b0;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_pop  = !empty && !dec_stall;
    assign fifo_push = rx_vld && (!full || fifo_pop);
    assign pop_byte  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (fifo_push) mem[wr_ptr[AW-1:0]] <= rx_byte;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (rx_vld && !fifo_push) overflow <= 1'b1;
        end
    end

    // Decoder FSM
    dec_state_t state, state_nxt;
    dec_act_t   act;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        act       = '0;
        if (fifo_pop) begin
            case (state)
                ST_IDLE: begin
                    if (pop_byte == CODE_E0)      state_nxt = ST_EXT;
                    else if (pop_byte == CODE_F0) state_nxt = ST_BRK;
                    else                          act.make  = 1'b1;
                end
                ST_EXT: begin
                    if (pop_byte == CODE_F0) begin
                        state_nxt = ST_EXT_BRK;
                    end else begin
                        act.make  = 1'b1;
                        act.ext   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    act.brk   = 1'b1;
                    state_nxt = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    act.brk   = 1'b1;
                    act.ext   = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    logic [7:0] held_code, press_cnt;
    logic       held_ext, held_vld, same_key;

    assign same_key = held_vld && (pop_byte == held_code) && (act.ext == held_ext);

    always_ff @(posedge clock) begin
        if (reset) begin
            held_code <= '0;
            held_ext  <= 1'b0;
            held_vld  <= 1'b0;
            press_cnt <= '0;
        end else if (act.make && !same_key) begin
            held_code <= pop_byte;
            held_ext  <= act.ext;
            held_vld  <= 1'b1;
            press_cnt <= press_cnt + 8'd1;
        end else if (act.brk && same_key) begin
            held_vld  <= 1'b0;
        end
    end

    // Display stage: one register after the decoder state.
    logic [7:0] ascii;
    assign ascii = ascii_of(held_code, held_ext);

    always_ff @(posedge clock) begin
        if (reset) begin
            key_held <= 1'b0;
            io_seg1  <= seg_out(SEG_BLANK);
            io_seg2  <= seg_out(SEG_BLANK);
            io_seg3  <= seg_out(SEG_BLANK);
            io_seg4  <= seg_out(SEG_BLANK);
            io_seg5  <= seg_out(SEG_HEX[0]);
            io_seg6  <= seg_out(SEG_HEX[0]);
        end else begin
            key_held <= held_vld;
            io_seg1  <= seg_out(held_vld ? SEG_HEX[held_code[3:0]] : SEG_BLANK);
            io_seg2  <= seg_out(held_vld ? SEG_HEX[held_code[7:4]] : SEG_BLANK);
            io_seg3  <= seg_out(held_vld ? SEG_HEX[ascii[3:0]]     : SEG_BLANK);
            io_seg4  <= seg_out(held_vld ? SEG_HEX[ascii[7:4]]     : SEG_BLANK);
            io_seg5  <= seg_out(SEG_HEX[press_cnt[3:0]]);
            io_seg6  <= seg_out(SEG_HEX[press_cnt[7:4]]);
        end
    end

endmodule

// File: tb/tb_kbd_seg_ctrl.sv
// Scoreboard bench for kbd_seg_ctrl: each issued scancode pushes the expected
// display snapshot; a monitor pops it when the decoder consumes a FIFO byte.
module tb_kbd_seg_ctrl;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int H     = 4;

    logic       clock = 1'b0;
    logic       reset, ps2_clk, ps2_data;
    logic [6:0] io_seg1, io_seg2, io_seg3, io_seg4, io_seg5, io_seg6;
    logic       key_held, parity_err, overflow;

    int checks = 0, failures = 0;
    int pe_seen = 0, pe_exp = 0;

    always #5 clock = ~clock;

    kbd_seg_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .io_seg1(io_seg1), .io_seg2(io_seg2), .io_seg3(io_seg3),
        .io_seg4(io_seg4), .io_seg5(io_seg5), .io_seg6(io_seg6),
        .key_held(key_held), .parity_err(parity_err), .overflow(overflow)
    );

    typedef struct packed {
        logic kh;
        logic [6:0] s1, s2, s3, s4, s5, s6;
    } snap_t;

    snap_t exp_q[$];
    snap_t pend0, pend1, cur;
    logic  pv0 = 1'b0, pv1 = 1'b0, pe_prev = 1'b0;

    // Reference model state
    int         m_st;
    logic [7:0] m_code, m_cnt;
    logic       m_ext, m_kh;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Active-low hex digit patterns
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [7:0] asc_of(input logic [7:0] c, input logic e);
        if (e) return 8'h00;
        case (c)
            8'h1C: return 8'h41; 8'h32: return 8'h42; 8'h1B: return 8'h53; 8'h29: return 8'h20;
            8'h16: return 8'h31; 8'h1E: return 8'h32; 8'h26: return 8'h33; 8'h25: return 8'h34;
            8'h2E: return 8'h35; 8'h36: return 8'h36; 8'h3D: return 8'h37; 8'h3E: return 8'h38;
            8'h46: return 8'h39;
            default: return 8'h00;
        endcase
    endfunction

    function automatic snap_t mk_snap(input logic kh, input logic [7:0] code,
                                      input logic [7:0] asc, input logic [7:0] cnt);
        snap_t s;
        s.kh = kh;
        s.s1 = kh ? seg_of(code[3:0]) : 7'h7F;
        s.s2 = kh ? seg_of(code[7:4]) : 7'h7F;
        s.s3 = kh ? seg_of(asc[3:0])  : 7'h7F;
        s.s4 = kh ? seg_of(asc[7:4])  : 7'h7F;
        s.s5 = seg_of(cnt[3:0]);
        s.s6 = seg_of(cnt[7:4]);
        return s;
    endfunction

    task automatic m_make(input logic [7:0] b, input logic e);
        if (!m_kh || b != m_code || e != m_ext) begin
            m_code = b; m_ext = e; m_kh = 1'b1; m_cnt = m_cnt + 8'd1;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (m_st)
            0: if (b == 8'hE0) m_st = 1; else if (b == 8'hF0) m_st = 2; else m_make(b, 1'b0);
            1: if (b == 8'hF0) m_st = 3; else begin m_make(b, 1'b1); m_st = 0; end
            default: begin
                if (m_kh && b == m_code && ((m_st == 3) == m_ext)) m_kh = 1'b0;
                m_st = 0;
            end
        endcase
        exp_q.push_back(mk_snap(m_kh, m_code, asc_of(m_code, m_ext), m_cnt));
    endtask

    // Scoreboard monitor: outputs reflect a popped byte two cycles after the pop.
    always @(negedge clock) begin
        cur = {key_held, io_seg1, io_seg2, io_seg3, io_seg4, io_seg5, io_seg6};
        if (reset) begin
            pv0 = 1'b0; pv1 = 1'b0;
            exp_q.delete();
        end else begin
            if (pv1) chk("decode_snapshot", 64'(cur), 64'(pend1));
            pv1 = pv0; pend1 = pend0; pv0 = 1'b0;
            if (dut.fifo_pop) begin
                if (exp_q.size() == 0) chk("unexpected_pop", 64'(1), 64'(0));
                else begin pend0 = exp_q.pop_front(); pv0 = 1'b1; end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && parity_err) begin
            pe_seen++;
            chk("parity_err_one_cycle", 64'(pe_prev), 64'(0));
        end
        pe_prev = parity_err;
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (H) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic send_raw(input logic [7:0] d, input logic par_flip, input logic stop_bad);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ par_flip);
        ps2_bit(~stop_bad);
        ps2_data = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    task automatic send(input logic [7:0] d);
        model_byte(d);
        send_raw(d, 1'b0, 1'b0);
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b1;
        m_st = 0; m_code = 8'h00; m_cnt = 8'h00; m_ext = 1'b0; m_kh = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_idle;
        int n = 0;
        while ((exp_q.size() != 0 || pv0 || pv1) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("drain_timeout", 64'(n < 2000), 64'(1));
        repeat (3) @(negedge clock);
    endtask

    task automatic chk_snap(input string name, input snap_t e);
        chk(name, 64'({key_held, io_seg1, io_seg2, io_seg3, io_seg4, io_seg5, io_seg6}), 64'(e));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        do_reset();
        chk_snap("reset_display", {1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40});
        chk("reset_overflow", 64'(overflow), 64'(0));
        chk("reset_parity_err", 64'(parity_err), 64'(0));

        // 'A' make, repeats, then break
        send(8'h1C); wait_idle();
        chk_snap("make_A", {1'b1, 7'h46, 7'h79, 7'h79, 7'h19, 7'h79, 7'h40});
        send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); wait_idle();
        chk_snap("typematic_break", {1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40});

        // Extended key
        do_reset();
        send(8'hE0); send(8'h75); wait_idle();
        chk_snap("ext_make", {1'b1, 7'h12, 7'h78, 7'h40, 7'h40, 7'h79, 7'h40});
        send(8'hE0); send(8'hF0); send(8'h75); wait_idle();
        chk_snap("ext_break", {1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40});

        // Bad stop bit, a lone start-bit-high edge, then Space
        send_raw(8'h29, 1'b0, 1'b1); pe_exp++;
        ps2_bit(1'b1);
        send(8'h29); wait_idle();
        chk_snap("space_after_errs", {1'b1, 7'h10, 7'h24, 7'h40, 7'h24, 7'h24, 7'h40});

        // Wrong parity on '1'
`ifdef KBD_PARITY_CHK_EN
        send_raw(8'h16, 1'b1, 1'b0); pe_exp++; wait_idle();
        chk_snap("bad_parity_reject", {1'b1, 7'h10, 7'h24, 7'h40, 7'h24, 7'h24, 7'h40});
`else
        model_byte(8'h16); send_raw(8'h16, 1'b1, 1'b0); wait_idle();
        chk_snap("bad_parity_accept", {1'b1, 7'h02, 7'h79, 7'h79, 7'h30, 7'h30, 7'h40});
`endif
        chk("parity_err_count", 64'(pe_seen), 64'(pe_exp));

        // Reset mid-frame discards the partial frame
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        do_reset();
        send(8'h16); wait_idle();
        chk_snap("after_midframe_reset", {1'b1, 7'h02, 7'h79, 7'h79, 7'h30, 7'h79, 7'h40});

        // Overflow with decoder stalled
        do_reset();
        force dut.dec_stall = 1'b1;
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        send(8'h2E); send(8'h36); send(8'h3D); send(8'h3E);
        send_raw(8'h46, 1'b0, 1'b0);
        chk("overflow_set", 64'(overflow), 64'(1));
        release dut.dec_stall;
        wait_idle();
        chk_snap("overflow_drain_last", {1'b1, 7'h06, 7'h30, 7'h00, 7'h30, 7'h00, 7'h40});
        chk("overflow_sticky", 64'(overflow), 64'(1));
        do_reset();
        chk("overflow_cleared", 64'(overflow), 64'(0));

        // Count wrap over 256 alternating makes
        for (int i = 0; i < 256; i++) send((i % 2 == 1) ? 8'h32 : 8'h1C);
        wait_idle();
        chk_snap("count_wrap", {1'b1, 7'h24, 7'h30, 7'h24, 7'h19, 7'h40, 7'h40});

        // Partial frame abandoned by timeout, then 'S'
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TMO + 50) @(negedge clock);
        send(8'h1B); wait_idle();
        chk_snap("timeout_then_S", {1'b1, 7'h03, 7'h79, 7'h30, 7'h12, 7'h79, 7'h40});
        chk("parity_err_total", 64'(pe_seen), 64'(pe_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
